stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer: the data-steering inverse of the team's 2:1 select mux (z = c ? b : a).
- Accepts one word per cycle on a valid/ready input, routes it by a select field into one of N single-entry output slots, and holds it there until that output's consumer takes it.
- Sits between a single producer (e.g. the writeback/result bus) and N independent consumers.
- Keeps a per-output delivered-word counter and a sticky error flag for illegal selects.

Parameters:
- W, 8, data word width in bits.
- N, 2, number of output ports (N >= 2).
- SELW, 1, select width; must satisfy 2^SELW >= N.
- CW, 8, width of each per-output delivery counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  input word.
- in_sel  input  SELW  destination index.
- in_valid  input  1  producer has a word.
- in_ready  output  1  demux can accept this cycle.
- out_data  output  N*W  slot k occupies bits [k*W +: W].
- out_valid  output  N  slot k holds a word.
- out_ready  input  N  consumer k takes its word this cycle.
- out_cnt  output  N*CW  words delivered on port k, in bits [k*CW +: CW].
- err  output  1  sticky; set by an accepted word with in_sel >= N.

Behaviour:
- Reset (synchronous, active-high) sets out_valid = 0 and out_data = 0 for all k, out_cnt = 0, err = 0.
- in_ready is 0 while rst is 1.
- Words held in slots at reset are discarded; no delivery is counted for them.
- Per-slot state machine, two states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain with no load.
  - FULL -> FULL on drain plus load in the same cycle; the new word replaces the old and the slot stays valid.
- drain_k = out_valid[k] & out_ready[k].
- in_ready (combinational, may depend on in_sel):
  - 1 when in_sel >= N;
  - otherwise ~out_valid[in_sel] | out_ready[in_sel].
  - It is never a function of in_valid.
- accept = in_valid & in_ready.
- Legal select (in_sel < N), on accept:
  - load slot in_sel at the next edge.
  - Latency: input accept to out_valid high is exactly 1 cycle.
- Illegal select (in_sel >= N), on accept:
  - word is consumed and dropped;
  - err is set the next cycle and stays set until rst;
  - no slot or counter changes.
- Only the selected slot is affected by an accept. Other slots keep their contents, and drain independently in the same cycle.
- out_data[k] is stable while out_valid[k] = 1 and out_ready[k] = 0.
- Counters:
  - out_cnt[k] increments by 1 on every drain_k.
  - Modulo 2^CW: it wraps from all-ones to 0 with no flag.
- Full throughput: one word per cycle to the same port is sustained while out_ready of that port is held at 1.
- Back-to-back accepts to different ports are independent.
- out_ready[k] while out_valid[k] = 0 is ignored.
- No combinational path from in_data to any output; out_data and out_valid come straight from registers.

Decomposition:
- Shared package holds:
  - default constants for W, N and CW;
  - a localparam helper for the select-legal check;
  - a two-value slot state enum, EMPTY and FULL.
- One sub-module is natural: demux_slot (one per output, generated N times).
  - Contains the W-bit holding register, the valid bit, load/drain logic and the CW-bit counter.
- The top level contains the select decode, the in_ready mux and the err flag.

Test Plan:
- Reset, then idle, with all out_ready = 1 -> out_valid = 00, out_cnt all 0, err = 0, in_ready = 1 for in_sel = 0 and for in_sel = 1.
- Send 8'hA5 to sel 0, then 8'h3C to sel 1, with out_ready = 00 -> out_data[0] = A5 and out_data[1] = 3C, each 1 cycle after accept; then in_ready = 0 for both selects; data is held stable for 5 cycles.
- Slot 0 holds A5; assert out_ready[0] = 1 in the same cycle as in_valid = 1, in_sel = 0, in_data = 8'h11 -> A5 is counted (out_cnt[0] = 1), slot 0 shows 11 the next cycle, and out_valid[0] never drops.
- Stream 10 consecutive words to port 1 with out_ready[1] = 1 -> one accept per cycle, out_cnt[1] = 10, port 0 untouched.
- N = 3, SELW = 2: send in_sel = 3 -> in_ready = 1, word dropped, err = 1 the next cycle, no out_valid change; err persists until rst.
- CW = 4: deliver 17 words on port 0 -> out_cnt[0] = 1 (wrapped). Then assert rst while both slots are FULL -> next cycle out_valid = 00, counters 0, err 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: default sizes, the slot
// state encoding and the select-legality helper used by the top level.
package stream_demux_pkg;

  localparam int DEFAULT_W    = 8;
  localparam int DEFAULT_N    = 2;
  localparam int DEFAULT_SELW = 1;
  localparam int DEFAULT_CW   = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // A select addresses a real output only when it is below the port count.
  function automatic logic sel_is_legal(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One single-entry output slot: holds a word until its consumer takes it and
// counts every word delivered through this port.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          ready,
  output logic [W-1:0]  data,
  output logic          valid,
  output logic [CW-1:0] cnt
);

  slot_state_t state;
  logic        drain;

  assign valid = (state == FULL);
  assign drain = valid & ready;

  // A load while full only happens when the old word drains in the same
  // cycle, so the new word simply overwrites it and the slot stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
      cnt   <= '0;
    end else begin
      if (drain) begin
        cnt <= cnt + 1'b1;
      end
      unique case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
            data  <= load_data;
          end
        end
        FULL: begin
          if (load) begin
            data <= load_data;
          end else if (ready) begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: steers each accepted word into the
// slot named by in_sel and flags words addressed to non-existent ports.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int W    = DEFAULT_W,
  parameter int N    = DEFAULT_N,
  parameter int SELW = DEFAULT_SELW,
  parameter int CW   = DEFAULT_CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*CW-1:0] out_cnt,
  output logic            err
);

  logic         sel_legal;
  logic         sel_valid;
  logic         sel_ready;
  logic         accept;
  logic [N-1:0] load;

  assign sel_legal = sel_is_legal(32'(in_sel), N);

  always_comb begin
    sel_valid = 1'b0;
    sel_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_valid = out_valid[k];
        sel_ready = out_ready[k];
      end
    end
  end

  // Illegal selects are always accepted so a bad word can never stall the producer.
  assign in_ready = ~rst & (~sel_legal | ~sel_valid | sel_ready);
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign load[g] = accept & (in_sel == SELW'(g));

    demux_slot #(
      .W (W),
      .CW(CW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[g]),
      .load_data(in_data),
      .ready    (out_ready[g]),
      .data     (out_data[g*W +: W]),
      .valid    (out_valid[g]),
      .cnt      (out_cnt[g*CW +: CW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept & ~sel_legal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Randomised self-checking bench for stream_demux (N=3, SELW=2, CW=4) with a
// behavioural reference model and directed literal checks.
module tb_stream_demux;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int SELW = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    in_data = '0;
  logic [SELW-1:0] in_sel = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*W-1:0]  out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready = '0;
  logic [N*CW-1:0] out_cnt;
  logic            err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int acc    = 0;

  always #5 clk = ~clk;

  stream_demux #(.W(W), .N(N), .SELW(SELW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt  (out_cnt),
    .err      (err)
  );

  // Reference model: one array entry per possible select value, counts kept unbounded.
  bit         mv[4];
  logic [7:0] md[4];
  int         mc[4];
  bit         me;
  bit         nv[4];
  logic [7:0] nd[4];
  int         nc[4];
  bit         ne;
  bit         m_ready;
  logic [3:0] ordy4;

  always_comb begin
    ordy4 = {1'b0, out_ready};
    if (rst) m_ready = 1'b0;
    else if (int'(in_sel) >= N) m_ready = 1'b1;
    else m_ready = !mv[in_sel] || ordy4[in_sel];
    nv = mv;
    nd = md;
    nc = mc;
    ne = me;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        nv[k] = 1'b0;
        nd[k] = '0;
        nc[k] = 0;
      end
      ne = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mv[k] && ordy4[k]) begin
          nc[k] = mc[k] + 1;
          nv[k] = 1'b0;
        end
      end
      if (in_valid && m_ready) begin
        if (int'(in_sel) < N) begin
          nv[in_sel] = 1'b1;
          nd[in_sel] = in_data;
        end else begin
          ne = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    mv <= nv;
    md <= nd;
    mc <= nc;
    me <= ne;
    if (chk_en && in_valid && in_ready) acc <= acc + 1;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge and return at the falling edge.
  task automatic applyStimulus(input bit r, input bit v, input int sel, input int data, input int ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_sel    = SELW'(sel);
    in_data   = W'(data);
    out_ready = N'(ordy);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("in_ready", int'(in_ready), int'(m_ready));
      checkOutput("err", int'(err), int'(me));
      for (int k = 0; k < N; k++) begin
        checkOutput("out_valid", int'(out_valid[k]), int'(mv[k]));
        if (mv[k]) checkOutput("out_data", int'(out_data[k*W +: W]), int'(md[k]));
        checkOutput("out_cnt", int'(out_cnt[k*CW +: CW]), mc[k] % 16);
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);

    applyStimulus(0, 0, 0, 0, 7);
    checkOutput("idle_valid", int'(out_valid), 0);
    checkOutput("idle_cnt", int'(out_cnt), 0);
    checkOutput("idle_err", int'(err), 0);
    checkOutput("idle_ready_sel0", int'(in_ready), 1);
    applyStimulus(0, 0, 1, 0, 7);
    checkOutput("idle_ready_sel1", int'(in_ready), 1);

    applyStimulus(0, 1, 0, 8'hA5, 0);
    checkOutput("latency_not_yet", int'(out_valid[0]), 0);
    applyStimulus(0, 1, 1, 8'h3C, 0);
    checkOutput("a5_valid", int'(out_valid), 3'b001);
    checkOutput("a5_data", int'(out_data[7:0]), 8'hA5);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("both_valid", int'(out_valid), 3'b011);
    checkOutput("3c_data", int'(out_data[15:8]), 8'h3C);
    checkOutput("full_ready_sel0", int'(in_ready), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("full_ready_sel1", int'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("hold_a5", int'(out_data[7:0]), 8'hA5);
      checkOutput("hold_3c", int'(out_data[15:8]), 8'h3C);
    end

    applyStimulus(0, 1, 0, 8'h11, 3'b001);
    checkOutput("replace_ready", int'(in_ready), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("replace_cnt0", int'(out_cnt[3:0]), 1);
    checkOutput("replace_data", int'(out_data[7:0]), 8'h11);
    checkOutput("replace_valid", int'(out_valid[0]), 1);

    applyStimulus(1, 0, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, i + 1, 3'b010);
      checkOutput("stream_ready", int'(in_ready), 1);
    end
    applyStimulus(0, 0, 0, 0, 3'b010);
    applyStimulus(0, 0, 0, 0, 3'b010);
    checkOutput("stream_accepts", acc, 10);
    checkOutput("stream_cnt1", int'(out_cnt[7:4]), 10);
    checkOutput("stream_cnt0", int'(out_cnt[3:0]), 0);
    checkOutput("stream_valid", int'(out_valid), 0);

    applyStimulus(0, 1, 3, 8'hEE, 0);
    checkOutput("illegal_ready", int'(in_ready), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("illegal_err", int'(err), 1);
    checkOutput("illegal_valid", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("err_sticky", int'(err), 1);

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, i, 3'b001);
    applyStimulus(0, 0, 0, 0, 3'b001);
    applyStimulus(0, 0, 0, 0, 3'b001);
    checkOutput("wrap_cnt0", int'(out_cnt[3:0]), 1);
    applyStimulus(0, 1, 0, 8'h77, 0);
    applyStimulus(0, 1, 1, 8'h88, 0);
    applyStimulus(0, 1, 3, 8'h99, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("prerst_valid", int'(out_valid), 3'b011);
    checkOutput("prerst_err", int'(err), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("inrst_ready", int'(in_ready), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("postrst_valid", int'(out_valid), 0);
    checkOutput("postrst_cnt", int'(out_cnt), 0);
    checkOutput("postrst_err", int'(err), 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
